digiac_ram_sched: RTL and testbench

- Time-slot scheduler for the shared single-port program/data RAM in the Digiac Mac III FPGA build.
- Generates the CPU bus phases (phi2, cpu_clken) from clk50.
- Gives the CPU the RAM during phi2 high, and inserts one debug-loader access (from the UART monitor) per CPU cycle during phi1.
- Supports a halt mode that freezes the CPU and serves debug accesses back-to-back.

---
 rtl/digiac_ram_sched.sv | 132 +++++++++++++
 tb/tb_digiac_ram_sched.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digiac_ram_sched.sv
// Time-slot scheduler for the shared single-port program/data RAM: CPU owns phi2,
// one debug-loader access per CPU cycle in phi1, plus a halted mode with back-to-back debug accesses.
module digiac_ram_sched #(
    parameter int ADDR_WIDTH = 11,
    parameter int PERIOD     = 50,
    parameter int DBG_SLOT   = 5
) (
    input  logic                  clk50,
    input  logic                  reset,
    output logic                  phi2,
    output logic                  cpu_clken,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [7:0]            dbg_wdata,
    output logic                  dbg_ack,
    output logic [7:0]            dbg_rdata,
    input  logic                  dbg_halt,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    localparam int CW = $clog2(PERIOD);

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_HALF  = CW'(PERIOD / 2);
    localparam logic [CW-1:0] C_WR    = CW'(PERIOD - 2);
    localparam logic [CW-1:0] C_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] C_SLOT  = CW'(DBG_SLOT);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_H_IDLE  = 3'd1;
    localparam logic [2:0] S_H_ISSUE = 3'd2;
    localparam logic [2:0] S_H_LATCH = 3'd3;
    localparam logic [2:0] S_H_ACK   = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  dbg_live;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [7:0]            wdata_hold;
    logic                  cpu_own;
    logic                  dbg_issue;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RUN: begin
                if (cnt == C_LAST) begin
                    cnt_nxt = '0;
                    if (dbg_halt) state_nxt = S_H_IDLE;
                end else begin
                    cnt_nxt = cnt + C_ONE;
                end
            end
            S_H_IDLE: begin
                if (dbg_req) begin
                    state_nxt = S_H_ISSUE;
                end else if (!dbg_halt) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = C_ONE;
                end
            end
            S_H_ISSUE: state_nxt = S_H_LATCH;
            S_H_LATCH: state_nxt = S_H_ACK;
            S_H_ACK:   state_nxt = S_H_IDLE;
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign cpu_own   = (state == S_RUN) && (cnt >= C_HALF);
    assign dbg_issue = ((state == S_RUN) && (cnt == C_SLOT) && dbg_req) || (state == S_H_ISSUE);

    // Outside any owner's slot the address/data buses park on their last driven value.
    always_comb begin
        ram_addr  = addr_hold;
        ram_wdata = wdata_hold;
        ram_we    = 1'b0;
        if (cpu_own) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we && (cnt == C_WR);
        end else if (dbg_issue) begin
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_we    = dbg_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            cnt        <= '0;
            phi2       <= 1'b0;
            cpu_clken  <= 1'b0;
            halted     <= 1'b0;
            dbg_live   <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= 8'h00;
            dbg_rdata  <= 8'h00;
            addr_hold  <= '0;
            wdata_hold <= 8'h00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            // Phase outputs are registered from the next count so they line up with cnt.
            phi2       <= (state_nxt == S_RUN) && (cnt_nxt >= C_HALF);
            cpu_clken  <= (state_nxt == S_RUN) && (cnt_nxt == C_LAST);
            halted     <= (state_nxt != S_RUN);
            dbg_live   <= (state == S_RUN) && (cnt == C_SLOT) && dbg_req;
            dbg_ack    <= dbg_live || (state == S_H_LATCH);
            if (dbg_live || (state == S_H_LATCH)) dbg_rdata <= ram_rdata;
            if ((state == S_RUN) && (cnt == C_WR)) cpu_rdata <= ram_rdata;
            addr_hold  <= ram_addr;
            wdata_hold <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_digiac_ram_sched.sv
// Self-checking bench for digiac_ram_sched: synchronous RAM environment plus a
// cycle-level reference model of the slot schedule, halt mode and memory contents.
module tb_digiac_ram_sched;

    localparam int AW   = 11;
    localparam int P    = 50;
    localparam int SLOT = 5;

    logic          clk50 = 1'b0;
    logic          reset = 1'b1;
    logic          init_req = 1'b1;
    logic          phi2, cpu_clken, dbg_ack, halted, ram_we;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_wdata = 8'h00;
    logic [7:0]    cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_halt = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [7:0]    dbg_wdata = 8'h00;
    logic [AW-1:0] ram_addr;

    logic [7:0] ram_mem [0:2**AW-1];
    logic [7:0] ref_mem [0:2**AW-1];

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    bit m_halted = 1'b0;
    int h_left = 0;

    digiac_ram_sched #(.ADDR_WIDTH(AW), .PERIOD(P), .DBG_SLOT(SLOT)) dut (
        .clk50(clk50), .reset(reset), .phi2(phi2), .cpu_clken(cpu_clken),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_halt(dbg_halt), .halted(halted),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk50 = ~clk50;

    // Synchronous read-first RAM, loaded from the reference image while init_req is high.
    always @(posedge clk50) begin
        if (init_req) begin
            for (int i = 0; i < 2**AW; i++) ram_mem[i] <= ref_mem[i];
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected TB_RESULT before it");
        $fatal(1);
    end

    // Reference model: advance one clk50 cycle using the inputs presented during it.
    task automatic adv();
        if (!m_halted) begin
            if (exp_cnt == P - 1 && dbg_halt) begin
                m_halted = 1'b1;
                exp_cnt  = 0;
                h_left   = 0;
            end else begin
                exp_cnt = (exp_cnt + 1) % P;
            end
        end else if (h_left > 0) begin
            h_left--;
        end else if (dbg_req) begin
            h_left = 3;
        end else if (!dbg_halt) begin
            m_halted = 1'b0;
            exp_cnt  = 1;
        end
        @(posedge clk50);
        #1;
    endtask

    task automatic go_to(input int target);
        for (int i = 0; i < 2 * P && exp_cnt != target; i++) adv();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        checks++;
        if ({phi2, cpu_clken, halted, dbg_ack, ram_we} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {phi2, cpu_clken, halted, dbg_ack, ram_we});
        end
        checks++;
        if ({cpu_rdata, dbg_rdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 0000", {cpu_rdata, dbg_rdata});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_ram_bus: got addr=%h wdata=%h expected 000/00", ram_addr, ram_wdata);
        end
        init_req = 1'b0;
        @(posedge clk50);
        #1;
        reset = 1'b0;
        exp_cnt = 0; m_halted = 1'b0; h_left = 0;
    endtask

    task automatic test_free_run();
        for (int k = 0; k < 3 * P; k++) begin
            @(negedge clk50);
            checks++;
            if ({phi2, cpu_clken, ram_we, halted} !== {(k % P) >= P / 2, (k % P) == P - 1, 2'b00}) begin
                failures++;
                $display("FAIL free_run cycle=%0d: got phi2/clken/we/halted=%b expected %b", k,
                         {phi2, cpu_clken, ram_we, halted}, {(k % P) >= P / 2, (k % P) == P - 1, 2'b00});
            end
            adv();
        end
    endtask

    task automatic test_cpu_access(input logic [AW-1:0] a, input logic [7:0] d);
        logic [7:0] old;
        go_to(P / 2);
        old = ref_mem[a];
        for (int c = P / 2; c < P; c++) begin
            cpu_addr = a; cpu_we = 1'b1; cpu_wdata = d;
            @(negedge clk50);
            checks++;
            if ({ram_addr, ram_wdata, ram_we} !== {a, d, c == P - 2}) begin
                failures++;
                $display("FAIL cpu_write cnt=%0d: got %h/%h/%b expected %h/%h/%b", c,
                         ram_addr, ram_wdata, ram_we, a, d, c == P - 2);
            end
            if (c == P - 1) begin
                checks++;
                if (cpu_rdata !== old) begin
                    failures++;
                    $display("FAIL cpu_read_before_write: got %h expected %h", cpu_rdata, old);
                end
            end
            if (c == P - 2) ref_mem[a] = d;
            adv();
        end
        cpu_we = 1'b0;
        for (int c = 0; c < P / 2; c++) begin
            cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
            @(negedge clk50);
            checks++;
            if ({ram_addr, ram_we} !== {a, 1'b0}) begin
                failures++;
                $display("FAIL cpu_idle_hold cnt=%0d: got %h/%b expected %h/0", c, ram_addr, ram_we, a);
            end
            adv();
        end
        cpu_addr = a;
        for (int c = P / 2; c < P; c++) begin
            @(negedge clk50);
            checks++;
            if (c == P - 1) begin
                if (cpu_rdata !== ref_mem[a]) begin
                    failures++;
                    $display("FAIL cpu_readback: got %h expected %h", cpu_rdata, ref_mem[a]);
                end
            end else if (ram_we !== 1'b0) begin
                failures++;
                $display("FAIL cpu_read_no_we cnt=%0d: got %b expected 0", c, ram_we);
            end
            adv();
        end
    endtask

    task automatic test_dbg_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d, input int raise);
        logic [7:0] old;
        go_to(raise);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        old = ref_mem[a];
        for (int c = raise; c <= SLOT + 3; c++) begin
            @(negedge clk50);
            if (c == SLOT) begin
                checks++;
                if ({ram_addr, ram_we} !== {a, we}) begin
                    failures++;
                    $display("FAIL dbg_issue: got %h/%b expected %h/%b", ram_addr, ram_we, a, we);
                end
                if (we) begin
                    checks++;
                    if (ram_wdata !== d) begin
                        failures++;
                        $display("FAIL dbg_wdata: got %h expected %h", ram_wdata, d);
                    end
                end
            end else begin
                checks++;
                if (ram_we !== 1'b0) begin
                    failures++;
                    $display("FAIL dbg_no_we cnt=%0d: got %b expected 0", c, ram_we);
                end
            end
            checks++;
            if (dbg_ack !== (c == SLOT + 2)) begin
                failures++;
                $display("FAIL dbg_ack cnt=%0d: got %b expected %b", c, dbg_ack, c == SLOT + 2);
            end
            if (c == SLOT + 2) begin
                if (!we) begin
                    checks++;
                    if (dbg_rdata !== old) begin
                        failures++;
                        $display("FAIL dbg_rdata: got %h expected %h", dbg_rdata, old);
                    end
                end
                dbg_req = 1'b0;
            end
            if (c == SLOT && we) ref_mem[a] = d;
            adv();
        end
        cpu_we = 1'b0;
        go_to(P / 2);
        cpu_addr = a;
        go_to(P - 1);
        @(negedge clk50);
        checks++;
        if (cpu_rdata !== ref_mem[a]) begin
            failures++;
            $display("FAIL dbg_cpu_readback: got %h expected %h", cpu_rdata, ref_mem[a]);
        end
        adv();
    endtask

    task automatic test_late_request(input int r, input logic [AW-1:0] a, input logic [7:0] d, input logic [AW-1:0] b);
        bit second;
        int c;
        second = 1'b0;
        go_to(SLOT + 1);
        for (int i = 0; i < P + 3; i++) begin
            c = exp_cnt;
            if (!second && c == r) begin
                dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = b;
            end
            cpu_addr = a; cpu_wdata = d; cpu_we = !second && c >= P / 2;
            @(negedge clk50);
            checks++;
            if (!second && c >= P / 2) begin
                if ({ram_addr, ram_we} !== {a, c == P - 2}) begin
                    failures++;
                    $display("FAIL late_cpu cnt=%0d: got %h/%b expected %h/%b", c, ram_addr, ram_we, a, c == P - 2);
                end
            end else if (second && c == SLOT) begin
                if ({ram_addr, ram_we} !== {b, 1'b0}) begin
                    failures++;
                    $display("FAIL late_issue: got %h/%b expected %h/0", ram_addr, ram_we, b);
                end
            end else if (ram_we !== 1'b0) begin
                failures++;
                $display("FAIL late_no_we cnt=%0d: got %b expected 0", c, ram_we);
            end
            checks++;
            if (dbg_ack !== (second && c == SLOT + 2)) begin
                failures++;
                $display("FAIL late_ack cnt=%0d: got %b expected %b", c, dbg_ack, second && c == SLOT + 2);
            end
            if (second && c == SLOT + 2) begin
                checks++;
                if (dbg_rdata !== ref_mem[b]) begin
                    failures++;
                    $display("FAIL late_rdata: got %h expected %h", dbg_rdata, ref_mem[b]);
                end
                dbg_req = 1'b0;
            end
            if (!second && c == P - 2) ref_mem[a] = d;
            adv();
            if (exp_cnt == 0) second = 1'b1;
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_halt();
        logic          we_l [6];
        logic [AW-1:0] a_l [6];
        logic [7:0]    d_l [6];
        logic [7:0]    old;
        a_l[0] = 11'h268; a_l[1] = 11'h269; a_l[2] = 11'h26A;
        a_l[3] = AW'($urandom_range(0, 11'h1FF)); a_l[4] = a_l[3];
        a_l[5] = AW'($urandom_range(0, 11'h1FF));
        for (int k = 0; k < 6; k++) begin
            we_l[k] = 1'b0;
            d_l[k]  = 8'($urandom);
        end
        we_l[3] = 1'b1;
        we_l[5] = 1'($urandom);
        go_to(10);
        dbg_halt = 1'b1;
        for (int c = 10; c < P; c++) begin
            @(negedge clk50);
            checks++;
            if ({cpu_clken, halted} !== {c == P - 1, 1'b0}) begin
                failures++;
                $display("FAIL halt_entry cnt=%0d: got clken/halted=%b expected %b", c,
                         {cpu_clken, halted}, {c == P - 1, 1'b0});
            end
            adv();
        end
        @(negedge clk50);
        checks++;
        if ({halted, phi2, cpu_clken} !== 3'b100) begin
            failures++;
            $display("FAIL halt_state: got halted/phi2/clken=%b expected 100", {halted, phi2, cpu_clken});
        end
        for (int k = 0; k < 6; k++) begin
            old = ref_mem[a_l[k]];
            dbg_req = 1'b1; dbg_we = we_l[k]; dbg_addr = a_l[k]; dbg_wdata = d_l[k];
            adv();
            @(negedge clk50);
            checks++;
            if ({ram_addr, ram_we, halted, phi2, cpu_clken} !== {a_l[k], we_l[k], 3'b100}) begin
                failures++;
                $display("FAIL halt_issue k=%0d: got %h/%b/%b expected %h/%b/100", k, ram_addr, ram_we,
                         {halted, phi2, cpu_clken}, a_l[k], we_l[k]);
            end
            if (we_l[k]) begin
                checks++;
                if (ram_wdata !== d_l[k]) begin
                    failures++;
                    $display("FAIL halt_wdata k=%0d: got %h expected %h", k, ram_wdata, d_l[k]);
                end
                ref_mem[a_l[k]] = d_l[k];
            end
            if (k == 5) dbg_halt = 1'b0;
            adv();
            @(negedge clk50);
            checks++;
            if ({dbg_ack, ram_we} !== 2'b00) begin
                failures++;
                $display("FAIL halt_latch k=%0d: got ack/we=%b expected 00", k, {dbg_ack, ram_we});
            end
            adv();
            @(negedge clk50);
            checks++;
            if ({dbg_ack, halted} !== 2'b11) begin
                failures++;
                $display("FAIL halt_ack k=%0d: got ack/halted=%b expected 11", k, {dbg_ack, halted});
            end
            if (!we_l[k]) begin
                checks++;
                if (dbg_rdata !== old) begin
                    failures++;
                    $display("FAIL halt_rdata k=%0d: got %h expected %h", k, dbg_rdata, old);
                end
            end
            dbg_req = 1'b0;
            adv();
            @(negedge clk50);
            checks++;
            if ({dbg_ack, halted} !== 2'b01) begin
                failures++;
                $display("FAIL halt_idle k=%0d: got ack/halted=%b expected 01", k, {dbg_ack, halted});
            end
        end
        adv();
        for (int n = 1; n < P; n++) begin
            @(negedge clk50);
            checks++;
            if ({halted, phi2, cpu_clken} !== {1'b0, n >= P / 2, n == P - 1}) begin
                failures++;
                $display("FAIL halt_exit n=%0d: got halted/phi2/clken=%b expected %b", n,
                         {halted, phi2, cpu_clken}, {1'b0, n >= P / 2, n == P - 1});
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_access();
        go_to(SLOT - 2);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = AW'($urandom);
        repeat (3) adv();
        reset = 1'b1;
        dbg_req = 1'b0;
        #1;
        checks++;
        if ({phi2, cpu_clken, halted, dbg_ack, ram_we} !== 5'b00000) begin
            failures++;
            $display("FAIL rst_mid_ctrl: got %b expected 00000", {phi2, cpu_clken, halted, dbg_ack, ram_we});
        end
        checks++;
        if ({cpu_rdata, dbg_rdata} !== 16'h0000 || ram_addr !== '0 || ram_wdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_data: got rdata=%h addr=%h wdata=%h expected zeros",
                     {cpu_rdata, dbg_rdata}, ram_addr, ram_wdata);
        end
        @(posedge clk50);
        @(negedge clk50);
        checks++;
        if (dbg_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_ack: got %b expected 0", dbg_ack);
        end
        @(posedge clk50);
        #1;
        reset = 1'b0;
        exp_cnt = 0; m_halted = 1'b0; h_left = 0;
        for (int c = 0; c < P; c++) begin
            @(negedge clk50);
            checks++;
            if ({phi2, cpu_clken, dbg_ack, ram_we} !== {c >= P / 2, c == P - 1, 2'b00}) begin
                failures++;
                $display("FAIL rst_resume cnt=%0d: got %b expected %b", c,
                         {phi2, cpu_clken, dbg_ack, ram_we}, {c >= P / 2, c == P - 1, 2'b00});
            end
            adv();
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = 8'($urandom);
        test_reset();
        test_free_run();
        test_cpu_access(11'h268, 8'h34);
        repeat (2) test_cpu_access(AW'($urandom_range(0, 11'h1FF)), 8'($urandom));
        test_dbg_access(1'b1, 11'h269, 8'h12, 2);
        test_dbg_access(1'b0, 11'h269, 8'h00, SLOT);
        repeat (3) test_dbg_access(1'($urandom), AW'($urandom_range(0, 11'h1FF)), 8'($urandom),
                                   $urandom_range(0, SLOT));
        test_late_request(30, 11'h268, 8'h34, 11'h26A);
        test_late_request(SLOT + 1, AW'($urandom_range(0, 11'h1FF)), 8'($urandom), AW'($urandom_range(0, 11'h1FF)));
        test_late_request($urandom_range(SLOT + 1, P - 1), AW'($urandom_range(0, 11'h1FF)), 8'($urandom),
                          AW'($urandom_range(0, 11'h1FF)));
        test_halt();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
